// File: rtl/cross_overlay.sv
// Crosshair overlay on a raster pixel stream behind a single register stage.
// Optional blink (CROSS_OVERLAY_BLINK_EN) gates the cross on alternate frame groups.
module cross_overlay #(
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240,
  parameter int ARM_LEN      = 8,
  parameter int PIX_W        = 16,
  parameter int BLINK_FRAMES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ovl_en,
  input  logic [PIX_W-1:0] ovl_color,
  input  logic [15:0]      cx,
  input  logic [15:0]      cy,
  input  logic [PIX_W-1:0] s_data,
  input  logic             s_sof,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam logic [15:0] X_LAST = 16'(H_ACTIVE - 1);
  localparam logic [15:0] Y_LAST = 16'(V_ACTIVE - 1);
  localparam logic [15:0] ARM    = 16'(ARM_LEN);

  logic             m_valid_q, m_valid_d;
  logic [PIX_W-1:0] m_data_q, m_data_d;
  logic             m_sof_q, m_sof_d;
  logic             m_eol_q, m_eol_d;
  logic [15:0]      x_q, x_d, y_q, y_d;
  logic             en_q, en_d;
  logic [PIX_W-1:0] col_q, col_d;
  logic [15:0]      cx_q, cx_d, cy_q, cy_d;

  logic             xfer, en_new, en_cur, on_cross;
  logic [PIX_W-1:0] col_cur;
  logic [15:0]      x_cur, y_cur, cx_cur, cy_cur, dx, dy;

  assign s_ready = m_ready | ~m_valid_q;
  assign xfer    = s_valid & s_ready;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_sof   = m_sof_q;
  assign m_eol   = m_eol_q;

`ifdef CROSS_OVERLAY_BLINK_EN
  localparam int FW = $clog2(2 * BLINK_FRAMES + 1);
  localparam logic [FW-1:0] F_LAST = FW'(2 * BLINK_FRAMES - 1);
  localparam logic [FW-1:0] F_HALF = FW'(BLINK_FRAMES);

  logic [FW-1:0] fcnt_q, fcnt_d;

  // Blink phase is frozen per frame by folding it into the latched enable
  assign en_new = ovl_en & (fcnt_q < F_HALF);

  always_comb begin
    fcnt_d = fcnt_q;
    if (xfer && s_sof)
      fcnt_d = (fcnt_q == F_LAST) ? '0 : fcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) fcnt_q <= '0;
    else     fcnt_q <= fcnt_d;
  end
`else
  logic unused_blink;
  assign unused_blink = (BLINK_FRAMES != 0);
  assign en_new       = ovl_en;
`endif

  // A sof pixel is (0,0) and already uses the freshly sampled settings
  always_comb begin
    x_cur   = s_sof ? 16'd0 : x_q;
    y_cur   = s_sof ? 16'd0 : y_q;
    en_cur  = s_sof ? en_new : en_q;
    col_cur = s_sof ? ovl_color : col_q;
    cx_cur  = s_sof ? cx : cx_q;
    cy_cur  = s_sof ? cy : cy_q;
    dx = (x_cur >= cx_cur) ? x_cur - cx_cur : cx_cur - x_cur;
    dy = (y_cur >= cy_cur) ? y_cur - cy_cur : cy_cur - y_cur;
    on_cross = ((y_cur == cy_cur) && (dx <= ARM)) ||
               ((x_cur == cx_cur) && (dy <= ARM));
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sof_d   = m_sof_q;
    m_eol_d   = m_eol_q;
    x_d       = x_q;
    y_d       = y_q;
    en_d      = en_q;
    col_d     = col_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    if (xfer) begin
      m_valid_d = 1'b1;
      m_data_d  = (on_cross && en_cur) ? col_cur : s_data;
      m_sof_d   = s_sof;
      m_eol_d   = (x_cur == X_LAST);
      if (s_sof) begin
        en_d  = en_new;
        col_d = ovl_color;
        cx_d  = cx;
        cy_d  = cy;
      end
      if (x_cur == X_LAST) begin
        x_d = 16'd0;
        y_d = (y_cur == Y_LAST) ? 16'd0 : y_cur + 16'd1;
      end else begin
        x_d = x_cur + 16'd1;
        y_d = y_cur;
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      en_q      <= 1'b0;
      col_q     <= '0;
      cx_q      <= '0;
      cy_q      <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sof_q   <= m_sof_d;
      m_eol_q   <= m_eol_d;
      x_q       <= x_d;
      y_q       <= y_d;
      en_q      <= en_d;
      col_q     <= col_d;
      cx_q      <= cx_d;
      cy_q      <= cy_d;
    end
  end

endmodule

// File: tb/tb_cross_overlay.sv
// Directed bench for cross_overlay on a 32x24 image with a scoreboard queue.
// Covers reset, centred/edge crosses, stalls, mid-frame changes, reset flush, blink.
module tb_cross_overlay;

  localparam int H  = 32;
  localparam int V  = 24;
  localparam int AL = 8;
  localparam int BF = 2;
  localparam logic [15:0] GRN = 16'h07E0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ovl_en = 1'b0;
  logic [15:0] ovl_color = '0;
  logic [15:0] ovl_cx = '0;
  logic [15:0] ovl_cy = '0;
  logic [15:0] s_data = '0;
  logic        s_sof = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [15:0] m_data;
  logic        m_sof;
  logic        m_eol;
  logic        m_valid;
  logic        m_ready = 1'b0;

  always #5 clk = ~clk;

  cross_overlay #(
    .H_ACTIVE(H), .V_ACTIVE(V), .ARM_LEN(AL), .PIX_W(16), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .ovl_en(ovl_en), .ovl_color(ovl_color),
    .cx(ovl_cx), .cy(ovl_cy), .s_data(s_data), .s_sof(s_sof),
    .s_valid(s_valid), .s_ready(s_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_valid(m_valid), .m_ready(m_ready)
  );

  int checks = 0;
  int errors = 0;
  int hits = 0;
  int waits = 0;
  bit stall_mode = 0;
  logic [15:0] hit_color = GRN;
  logic [17:0] sbq[$];
  logic        held_v = 1'b0;
  logic [17:0] held = '0;

  always @(posedge clk) begin
    #1;
    if (stall_mode) m_ready = 1'($urandom_range(0, 1));
  end

  // Output monitor: sampled mid-cycle, inputs change just after posedge
  always @(negedge clk) begin
    logic [17:0] obs, expv;
    obs = {m_eol, m_sof, m_data};
    if (held_v && m_valid) begin
      checks++;
      assert (obs === held) else begin
        errors++;
        $error("FAIL hold obs=%h exp=%h", obs, held);
      end
    end
    held_v = m_valid && !m_ready && !rst;
    held = obs;
    if (!rst && m_valid && m_ready) begin
      checks++;
      assert (sbq.size() != 0) else begin
        errors++;
        $error("FAIL spurious_out obs=%h exp=none", obs);
      end
      if (sbq.size() != 0) begin
        expv = sbq.pop_front();
        checks++;
        assert (obs === expv) else begin
          errors++;
          $error("FAIL pixel obs=%h exp=%h", obs, expv);
        end
        if (m_data === hit_color) hits++;
      end
    end
  end

  function automatic bit on_x(int x, int y, int cx, int cy);
    int dx, dy;
    dx = (x > cx) ? x - cx : cx - x;
    dy = (y > cy) ? y - cy : cy - y;
    return ((y == cy) && (dx <= AL)) || ((x == cx) && (dy <= AL));
  endfunction

  task automatic send(input logic [15:0] d, input logic sof,
                      input logic [17:0] expv);
    bit fire;
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data = d;
    s_sof = sof;
    do begin
      @(negedge clk);
      fire = s_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!fire && n < 1000);
    checks++;
    assert (fire) else begin
      errors++;
      $error("FAIL accept_timeout obs=%0d exp=<1000", n);
    end
    if (fire) sbq.push_back(expv);
    waits += n - 1;
    s_valid = 1'b0;
    s_sof = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    assert (sbq.size() == 0) else begin
      errors++;
      $error("FAIL %s drain obs=%0d exp=0", tag, sbq.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic en, input int cx, input int cy,
                           input int cx_mid, input bit stall,
                           input bit draw, input int exp_hits,
                           input string tag);
    logic [15:0] d, o;
    stall_mode = stall;
    if (!stall) m_ready = 1'b1;
    hits = 0;
    waits = 0;
    ovl_en = en;
    ovl_color = GRN;
    ovl_cx = 16'(cx);
    ovl_cy = 16'(cy);
    for (int y = 0; y < V; y++) begin
      for (int x = 0; x < H; x++) begin
        d = 16'($urandom) & 16'hF81F;
        o = (en && draw && on_x(x, y, cx, cy)) ? GRN : d;
        send(d, (x == 0 && y == 0), {(x == H - 1), (x == 0 && y == 0), o});
        if (x == 0 && y == 0) begin
          ovl_cx = 16'(cx_mid);
          ovl_cy = 16'(cy + 3);
          ovl_en = ~en;
          ovl_color = 16'h1234;
        end
      end
    end
    if (!stall) begin
      checks++;
      assert (waits == 0) else begin
        errors++;
        $error("FAIL %s gaps obs=%0d exp=0", tag, waits);
      end
    end
    drain(tag);
    stall_mode = 0;
    m_ready = 1'b1;
    checks++;
    assert (hits == exp_hits) else begin
      errors++;
      $error("FAIL %s cross_px obs=%0d exp=%0d", tag, hits, exp_hits);
    end
  endtask

  initial begin
    logic [15:0] d;
    bit draw;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    assert ({m_valid, m_sof, m_eol, m_data} === 19'd0) else begin
      errors++;
      $error("FAIL reset_out obs=%h exp=0", {m_valid, m_sof, m_eol, m_data});
    end
    checks++;
    assert (s_ready === 1'b1) else begin
      errors++;
      $error("FAIL reset_ready obs=%b exp=1", s_ready);
    end
    rst = 1'b0;

    run_frame(1'b1, 16, 12, 16, 0, 1, 33, "centre");
    run_frame(1'b1, 2, 0, 2, 0, 1, 19, "edge");
    run_frame(1'b1, 40, 30, 40, 0, 1, 0, "outside");
    run_frame(1'b0, 16, 12, 16, 0, 1, 0, "disabled");
    run_frame(1'b1, 16, 12, 16, 1, 1, 33, "stall");
    run_frame(1'b1, 16, 12, 10, 1, 1, 33, "mid_old");
    run_frame(1'b1, 10, 12, 10, 0, 1, 33, "mid_new");

    // Partial frame up to (4,6), then (5,6) parked in the stage
    m_ready = 1'b1;
    ovl_en = 1'b1;
    ovl_color = GRN;
    ovl_cx = 16'd5;
    ovl_cy = 16'd6;
    for (int i = 0; i < 6 * H + 5; i++) begin
      d = 16'($urandom) & 16'hF81F;
      send(d, (i == 0), {(i % H == H - 1), (i == 0),
           on_x(i % H, i / H, 5, 6) ? GRN : d});
    end
    drain("pre_rst");
    m_ready = 1'b0;
    send(16'h0001, 1'b0, {2'b00, GRN});
    void'(sbq.pop_back());
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    assert ({m_valid, m_data} === 17'd0) else begin
      errors++;
      $error("FAIL rst_flush obs=%h exp=0", {m_valid, m_data});
    end
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    ovl_cx = 16'd0;
    ovl_cy = 16'd0;
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom) & 16'hF81F;
      send(d, 1'b0, {2'b00, d});
    end
    drain("post_rst_pass");
    run_frame(1'b1, 16, 12, 16, 0, 1, 33, "post_rst");

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
`ifdef CROSS_OVERLAY_BLINK_EN
      draw = ((k % (2 * BF)) < BF);
`else
      draw = 1'b1;
`endif
      run_frame(1'b1, 16, 12, 16, 0, draw, draw ? 33 : 0, "blink");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
